sell_coin_sched: RTL and testbench

- Front-end scheduler between the raw coin-acceptor sensors and the sell vending core.
- Synchronises and edge-detects the two coin sensors, then queues coin events in a small FIFO.
- Issues coins to sell as single-cycle one_dollar / half_dollar pulses with guaranteed spacing, and stalls while sell is vending.
- Rejects coins when the queue is full and keeps sale, change and reject statistics.

---
 rtl/sell_pkg.sv | 24 ++
 rtl/coin_fifo.sv | 52 +++++
 rtl/sell_coin_sched.sv | 189 ++++++++++++++++++
 tb/tb_sell_coin_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sell_pkg.sv
// Shared coin codes, scheduler states and timing defaults for the coin
// front-end that feeds the sell vending core.
package sell_pkg;

    localparam logic [1:0] COIN_DOLLAR = 2'b01;
    localparam logic [1:0] COIN_HALF   = 2'b10;
    localparam logic [1:0] COIN_BOTH   = 2'b11;

    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_VEND_HOLD  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_VEND  = 2'd3
    } sched_state_t;

    // Bits needed for a counter that must reach max_val (never less than one).
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO of 2-bit coin codes; a pop frees the slot for a
// same-cycle push even when the queue is full.
module coin_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sell_coin_sched.sv
// Coin front-end: synchronises the acceptor sensors, queues coin events and
// hands them to sell as spaced one-cycle pulses, stalling while sell vends.
module sell_coin_sched
    import sell_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int VEND_HOLD  = DEF_VEND_HOLD,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_dollar_sns,
    input  logic             coin_half_sns,
    output logic             one_dollar,
    output logic             half_dollar,
    input  logic             dispense,
    input  logic             half_out,
    input  logic             collect,
    output logic             coin_reject,
    output logic             busy,
    output logic [CNT_W-1:0] sales_cnt,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] reject_cnt
);

    localparam int GW = cnt_bits(GAP_CYCLES);
    localparam int HW = cnt_bits(VEND_HOLD);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(VEND_HOLD - 1);

    logic         dol_meta, dol_sync, dol_last;
    logic         half_meta, half_sync, half_last;
    logic         dol_edge, half_edge, push_req;
    logic [1:0]   push_code;
    logic         fifo_full, fifo_empty, pop;
    logic [1:0]   fifo_head;
    logic         reject_nxt;

    sched_state_t state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic         half_pend, half_pend_nxt;
    logic         issue_half, issue_half_nxt;
    logic         exit_now;
    logic         one_dollar_nxt, half_dollar_nxt;
    logic         disp_last, hout_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dol_meta  <= 1'b0;
            dol_sync  <= 1'b0;
            dol_last  <= 1'b0;
            half_meta <= 1'b0;
            half_sync <= 1'b0;
            half_last <= 1'b0;
        end else begin
            dol_meta  <= coin_dollar_sns;
            dol_sync  <= dol_meta;
            dol_last  <= dol_sync;
            half_meta <= coin_half_sns;
            half_sync <= half_meta;
            half_last <= half_sync;
        end
    end

    assign dol_edge   = dol_sync && !dol_last;
    assign half_edge  = half_sync && !half_last;
    assign push_req   = dol_edge || half_edge;
    assign push_code  = (dol_edge && half_edge) ? COIN_BOTH :
                        (dol_edge ? COIN_DOLLAR : COIN_HALF);
    assign reject_nxt = push_req && fifo_full && !pop;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    coin_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_code),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
            half_pend  <= 1'b0;
            issue_half <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            half_pend  <= half_pend_nxt;
            issue_half <= issue_half_nxt;
        end
    end

    // A code-11 coin parks its half in half_pend until the gap or vend ends.
    always_comb begin
        state_nxt      = state;
        gap_cnt_nxt    = gap_cnt;
        hold_cnt_nxt   = hold_cnt;
        half_pend_nxt  = half_pend;
        issue_half_nxt = issue_half;
        pop            = 1'b0;
        exit_now       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dispense) begin
                    state_nxt    = ST_VEND;
                    hold_cnt_nxt = '0;
                end else if (!fifo_empty) begin
                    pop            = 1'b1;
                    state_nxt      = ST_ISSUE;
                    issue_half_nxt = (fifo_head == COIN_HALF);
                    half_pend_nxt  = (fifo_head == COIN_BOTH);
                end
            end
            ST_ISSUE: begin
                state_nxt   = ST_GAP;
                gap_cnt_nxt = '0;
            end
            ST_GAP: begin
                if (dispense) begin
                    state_nxt    = ST_VEND;
                    hold_cnt_nxt = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    exit_now = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            ST_VEND: begin
                if (dispense || collect) begin
                    hold_cnt_nxt = '0;
                end else if (VEND_HOLD == 0 || hold_cnt == HOLD_LAST) begin
                    exit_now = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (exit_now) begin
            if (half_pend) begin
                state_nxt      = ST_ISSUE;
                issue_half_nxt = 1'b1;
                half_pend_nxt  = 1'b0;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        one_dollar_nxt  = (state_nxt == ST_ISSUE) && !issue_half_nxt;
        half_dollar_nxt = (state_nxt == ST_ISSUE) && issue_half_nxt;
    end

    // Pulses leave from flops so an async reset can never chop one into a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            one_dollar  <= 1'b0;
            half_dollar <= 1'b0;
            coin_reject <= 1'b0;
            disp_last   <= 1'b0;
            hout_last   <= 1'b0;
            sales_cnt   <= '0;
            change_cnt  <= '0;
            reject_cnt  <= '0;
        end else begin
            one_dollar  <= one_dollar_nxt;
            half_dollar <= half_dollar_nxt;
            coin_reject <= reject_nxt;
            disp_last   <= dispense;
            hout_last   <= half_out;
            if (dispense && !disp_last) sales_cnt  <= sales_cnt + 1'b1;
            if (half_out && !hout_last) change_cnt <= change_cnt + 1'b1;
            if (reject_nxt)             reject_cnt <= reject_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sell_coin_sched.sv
// Randomised and scenario stimulus for sell_coin_sched, checked every cycle
// against a timestamp-based reference model of the coin scheduling rules.
module tb_sell_coin_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 2;
    localparam int VEND_HOLD  = 3;
    localparam int CNT_W      = 8;
    localparam int HOLD_EFF   = (VEND_HOLD < 1) ? 1 : VEND_HOLD;

    logic clk = 1'b0;
    logic reset;
    logic coin_dollar_sns, coin_half_sns, dispense, half_out, collect;
    logic one_dollar, half_dollar, coin_reject, busy;
    logic [CNT_W-1:0] sales_cnt, change_cnt, reject_cnt;

    int n_checks;
    int n_errors;

    // Reference model: queue of coin codes plus the time of the last pulse.
    int q[$];
    bit m_idle, m_vend, m_owed;
    int m_quiet, m_pulse_edge, edge_no;
    bit dh1, dh2, dh3, hh1, hh2, hh3, disp_prev, hout_prev;
    bit exp_od, exp_hd, exp_rej, exp_busy;
    logic [CNT_W-1:0] exp_sales, exp_change, exp_rej_cnt;

    sell_coin_sched #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES),
        .VEND_HOLD  (VEND_HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .coin_dollar_sns (coin_dollar_sns),
        .coin_half_sns   (coin_half_sns),
        .one_dollar      (one_dollar),
        .half_dollar     (half_dollar),
        .dispense        (dispense),
        .half_out        (half_out),
        .collect         (collect),
        .coin_reject     (coin_reject),
        .busy            (busy),
        .sales_cnt       (sales_cnt),
        .change_cnt      (change_cnt),
        .reject_cnt      (reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_one_dollar"},  32'(one_dollar),  32'(exp_od));
        checkOutput({tag, "_half_dollar"}, 32'(half_dollar), 32'(exp_hd));
        checkOutput({tag, "_coin_reject"}, 32'(coin_reject), 32'(exp_rej));
        checkOutput({tag, "_busy"},        32'(busy),        32'(exp_busy));
        checkOutput({tag, "_sales_cnt"},   32'(sales_cnt),   32'(exp_sales));
        checkOutput({tag, "_change_cnt"},  32'(change_cnt),  32'(exp_change));
        checkOutput({tag, "_reject_cnt"},  32'(reject_cnt),  32'(exp_rej_cnt));
    endtask

    task automatic modelReset();
        q.delete();
        m_idle = 1; m_vend = 0; m_owed = 0; m_quiet = 0; m_pulse_edge = -100;
        {dh1, dh2, dh3, hh1, hh2, hh3, disp_prev, hout_prev} = '0;
        {exp_od, exp_hd, exp_rej, exp_busy} = '0;
        exp_sales = '0; exp_change = '0; exp_rej_cnt = '0;
    endtask

    // One clock edge of the model, using the input levels present at that edge.
    task automatic modelStep(input bit s_dol, input bit s_half, input bit disp,
                             input bit hout, input bit coll);
        bit rel, pd, ph;
        int c;
        rel = 0; exp_od = 0; exp_hd = 0; exp_rej = 0;
        edge_no++;
        pd = dh2 && !dh3;
        ph = hh2 && !hh3;
        dh3 = dh2; dh2 = dh1; dh1 = s_dol;
        hh3 = hh2; hh2 = hh1; hh1 = s_half;
        if (m_idle) begin
            if (disp) begin
                m_idle = 0; m_vend = 1; m_quiet = 0;
            end else if (q.size() > 0) begin
                c = q.pop_front();
                m_idle = 0; m_pulse_edge = edge_no; m_owed = (c == 3);
                if (c == 2) exp_hd = 1; else exp_od = 1;
            end
        end else if (m_vend) begin
            if (disp || coll) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= HOLD_EFF) begin m_vend = 0; rel = 1; end
            end
        end else if (edge_no >= m_pulse_edge + 2) begin
            if (disp) begin m_vend = 1; m_quiet = 0; end
            else if (edge_no == m_pulse_edge + GAP_CYCLES + 1) rel = 1;
        end
        if (rel) begin
            if (m_owed) begin m_owed = 0; exp_hd = 1; m_pulse_edge = edge_no; end
            else m_idle = 1;
        end
        if (pd || ph) begin
            if (q.size() < FIFO_DEPTH) q.push_back((pd && ph) ? 3 : (pd ? 1 : 2));
            else begin exp_rej = 1; exp_rej_cnt++; end
        end
        if (disp && !disp_prev) exp_sales++;
        if (hout && !hout_prev) exp_change++;
        disp_prev = disp; hout_prev = hout;
        exp_busy = (q.size() != 0) || !m_idle;
    endtask

    // Called at a falling edge; drives inputs, steps the model, checks next falling edge.
    task automatic applyStimulus(input bit s_dol, input bit s_half, input bit disp,
                                 input bit hout, input bit coll);
        coin_dollar_sns = s_dol; coin_half_sns = s_half;
        dispense = disp; half_out = hout; collect = coll;
        @(posedge clk);
        modelStep(s_dol, s_half, disp, hout, coll);
        @(negedge clk);
        checkAll("cyc");
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_one_dollar", 32'(one_dollar), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        modelReset();
        checkAll("rst_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit r_dol, r_half, r_disp, r_hout, r_coll;
        bit seen;
        n_checks = 0; n_errors = 0; edge_no = 0;
        reset = 1'b1;
        {coin_dollar_sns, coin_half_sns, dispense, half_out, collect} = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAll("reset");
        reset = 1'b0;

        // Three isolated dollar coins.
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1, 0, 0, 0, 0);
            repeat (5) applyStimulus(0, 0, 0, 0, 0);
        end
        repeat (4) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("s1_reject_cnt", 32'(reject_cnt), 0);

        // Both sensors in the same cycle.
        applyStimulus(1, 1, 0, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);

        // Five edges while sell is vending: one must be rejected.
        for (int i = 0; i < 5; i++) applyStimulus(i % 2 == 0, i % 2 == 1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        repeat (25) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("s3_reject_cnt", 32'(reject_cnt), 1);

        // Dispense inside the gap after a coin.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 0);

        // Reset while a dollar pulse is out and more coins are queued.
        for (int i = 0; i < 5; i++) applyStimulus(i % 2 == 0, 0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            seen = exp_od;
        end
        checkOutput("s5_issue_reached", 32'(seen), 1);
        doReset();
        repeat (8) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("s5_sales_cnt", 32'(sales_cnt), 0);
        checkOutput("s5_reject_cnt", 32'(reject_cnt), 0);

        // 256 change edges wrap the 8-bit counter.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (i == 254) checkOutput("s6_change_255", 32'(change_cnt), 255);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("s6_change_wrap", 32'(change_cnt), 0);

        // Random traffic.
        {r_dol, r_half, r_disp, r_hout, r_coll} = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) r_dol = ~r_dol;
            if ($urandom_range(0, 6) == 0) r_half = ~r_half;
            if ($urandom_range(0, 40) == 0 && !r_dol && !r_half) begin
                r_dol = 1; r_half = 1;
            end
            if (r_disp) r_disp = ($urandom_range(0, 3) != 0);
            else        r_disp = ($urandom_range(0, 29) == 0);
            r_coll = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) r_hout = ~r_hout;
            if ($urandom_range(0, 599) == 0) doReset();
            else applyStimulus(r_dol, r_half, r_disp, r_hout, r_coll);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
